// File: rtl/sisc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sisc_pkg
// Purpose  : Shared encodings for the SISC control/execute slice: opcodes,
//            ALU function codes, ALU operating modes, FSM state encoding and
//            status-flag bit positions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sisc_pkg;

  // Opcodes (instr[31:28])
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_BRA  = 4'h2;
  localparam logic [3:0] OP_BRR  = 4'h3;
  localparam logic [3:0] OP_BNE  = 4'h4;
  localparam logic [3:0] OP_BNR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU function codes (mm field when alu_op = ALU_RR)
  localparam logic [3:0] FN_ADD = 4'h1;
  localparam logic [3:0] FN_SUB = 4'h2;
  localparam logic [3:0] FN_AND = 4'h3;
  localparam logic [3:0] FN_OR  = 4'h4;
  localparam logic [3:0] FN_XOR = 4'h5;
  localparam logic [3:0] FN_NOT = 4'h6;
  localparam logic [3:0] FN_SHL = 4'h7;
  localparam logic [3:0] FN_SHR = 4'h8;

  // ALU operating modes
  localparam logic [1:0] ALU_RR   = 2'b00;
  localparam logic [1:0] ALU_ADDI = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

  // Flag bit indices within {C,V,N,Z}
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    ST_START0 = 3'd0,
    ST_START1 = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEM    = 3'd5,
    ST_WB     = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

endpackage : sisc_pkg
`default_nettype wire

// File: rtl/sisc_alu.sv
`default_nettype none
// ============================================================================
// Module   : sisc_alu
// Purpose  : Combinational ALU with {C,V,N,Z} status generation.
// Ports    : alu_op_i  mode (00 reg-reg, 01 reg+imm, 10 pass rsb, 11 zero)
//            func_i    function code for reg-reg mode
//            rsa_i     operand A
//            rsb_i     operand B (also shift amount in [4:0])
//            imm_i     16-bit immediate, sign-extended in reg+imm mode
//            result_o  ALU result
//            flags_o   {C,V,N,Z}
// Revision : 1.0 - initial release
// ============================================================================
module sisc_alu
  import sisc_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    alu_op_i,
  input  logic [3:0]    func_i,
  input  logic [DW-1:0] rsa_i,
  input  logic [DW-1:0] rsb_i,
  input  logic [15:0]   imm_i,
  output logic [DW-1:0] result_o,
  output logic [3:0]    flags_o
);

  logic [DW:0]   sum;
  logic [DW-1:0] imm_sx;
  logic [DW-1:0] res;
  logic          carry;
  logic          ovf;

  assign imm_sx = {{(DW-16){imm_i[15]}}, imm_i};

  always_comb begin
    sum   = '0;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (alu_op_i)
      ALU_RR: begin
        case (func_i)
          FN_ADD: begin
            sum   = {1'b0, rsa_i} + {1'b0, rsb_i};
            res   = sum[DW-1:0];
            carry = sum[DW];
            ovf   = (rsa_i[DW-1] == rsb_i[DW-1]) && (res[DW-1] != rsa_i[DW-1]);
          end
          FN_SUB: begin
            // Two's-complement subtract: carry-out is the "no borrow" flag.
            sum   = {1'b0, rsa_i} + {1'b0, ~rsb_i} + {{DW{1'b0}}, 1'b1};
            res   = sum[DW-1:0];
            carry = sum[DW];
            ovf   = (rsa_i[DW-1] != rsb_i[DW-1]) && (res[DW-1] != rsa_i[DW-1]);
          end
          FN_AND: res = rsa_i & rsb_i;
          FN_OR:  res = rsa_i | rsb_i;
          FN_XOR: res = rsa_i ^ rsb_i;
          FN_NOT: res = ~rsa_i;
          FN_SHL: res = rsa_i << rsb_i[4:0];
          FN_SHR: res = rsa_i >> rsb_i[4:0];
          default: res = '0;
        endcase
      end
      ALU_ADDI: begin
        sum   = {1'b0, rsa_i} + {1'b0, imm_sx};
        res   = sum[DW-1:0];
        carry = sum[DW];
        ovf   = (rsa_i[DW-1] == imm_sx[DW-1]) && (res[DW-1] != rsa_i[DW-1]);
      end
      ALU_PASS: res = rsb_i;
      default:  res = '0;
    endcase
  end

  assign result_o = res;
  assign flags_o  = {carry, ovf, res[DW-1], (res == '0)};

endmodule : sisc_alu
`default_nettype wire

// File: rtl/sisc_ctrl_exec.sv
`default_nettype none
// ============================================================================
// Module   : sisc_ctrl_exec
// Purpose  : SISC multicycle control FSM, ALU wrapper and branch-target adder.
// Ports    : clk, rst_f (async, active-low)
//            instr       IR contents     stat      status register {C,V,N,Z}
//            rsa, rsb    RF read ports   pc_in     incremented PC
//            alu_result  ALU result      stat_in   new flags
//            stat_en     flag load       br_addr   branch target
//            alu_op      ALU mode        rf_we, wb_sel, br_sel, pc_sel,
//                                        pc_write, ir_load  control strobes
// Revision : 1.0 - initial release
// ============================================================================
module sisc_ctrl_exec
  import sisc_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic [31:0]   instr,
  input  logic [3:0]    stat,
  input  logic [DW-1:0] rsa,
  input  logic [DW-1:0] rsb,
  input  logic [AW-1:0] pc_in,
  output logic [DW-1:0] alu_result,
  output logic [3:0]    stat_in,
  output logic          stat_en,
  output logic [AW-1:0] br_addr,
  output logic [1:0]    alu_op,
  output logic          rf_we,
  output logic          wb_sel,
  output logic          br_sel,
  output logic          pc_sel,
  output logic          pc_write,
  output logic          ir_load
);

  state_e        state_q, state_d;
  logic [3:0]    op;
  logic [3:0]    mm;
  logic [15:0]   imm;
  logic [AW-1:0] imm_aw;
  logic          cond_any;
  logic          unused_fields;

  assign op       = instr[31:28];
  assign mm       = instr[27:24];
  assign imm      = instr[15:0];
  assign imm_aw   = AW'(imm);
  assign cond_any = |(stat & mm);
  // rd/rs fields are consumed by the register file, not here.
  assign unused_fields = ^instr[23:16];

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state_q <= ST_START0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    alu_op   = ALU_PASS;
    stat_en  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_sel   = 1'b0;
    pc_write = 1'b0;
    ir_load  = 1'b0;
    case (state_q)
      ST_START0: state_d = ST_START1;
      ST_START1: state_d = ST_FETCH;
      ST_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = (op == OP_HALT) ? ST_HALT : ST_EXEC;
        // Branches resolve here so the PC is redirected before EXECUTE.
        case (op)
          OP_BRA: begin br_sel = 1'b1; pc_write = cond_any;  pc_sel = cond_any;  end
          OP_BRR: begin br_sel = 1'b0; pc_write = cond_any;  pc_sel = cond_any;  end
          OP_BNE: begin br_sel = 1'b1; pc_write = !cond_any; pc_sel = !cond_any; end
          OP_BNR: begin br_sel = 1'b0; pc_write = !cond_any; pc_sel = !cond_any; end
          default: ;
        endcase
      end
      ST_EXEC: begin
        state_d = ST_MEM;
        if (op == OP_ALU) begin
          alu_op  = ALU_RR;
          stat_en = 1'b1;
        end else if (op == OP_ADDI) begin
          alu_op  = ALU_ADDI;
          stat_en = 1'b1;
        end
      end
      ST_MEM: state_d = ST_WB;
      ST_WB: begin
        state_d = ST_FETCH;
        rf_we   = (op == OP_ALU) || (op == OP_ADDI);
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_START0;
    endcase
  end

  // Absolute targets use the immediate directly; relative ones wrap mod 2^AW.
  assign br_addr = br_sel ? imm_aw : (pc_in + imm_aw);

  sisc_alu #(
    .DW(DW)
  ) u_alu (
    .alu_op_i (alu_op),
    .func_i   (mm),
    .rsa_i    (rsa),
    .rsb_i    (rsb),
    .imm_i    (imm),
    .result_o (alu_result),
    .flags_o  (stat_in)
  );

endmodule : sisc_ctrl_exec
`default_nettype wire

// File: tb/tb_sisc_ctrl_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_sisc_ctrl_exec
// Purpose  : Directed self-checking bench for sisc_ctrl_exec.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sisc_ctrl_exec;

  logic        clk = 1'b0;
  logic        rst_f;
  logic [31:0] instr;
  logic [3:0]  stat;
  logic [31:0] rsa, rsb;
  logic [15:0] pc_in;
  logic [31:0] alu_result;
  logic [3:0]  stat_in;
  logic        stat_en;
  logic [15:0] br_addr;
  logic [1:0]  alu_op;
  logic        rf_we, wb_sel, br_sel, pc_sel, pc_write, ir_load;

  int n_cmp = 0;
  int n_err = 0;

  sisc_ctrl_exec #(.DW(32), .AW(16)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .instr      (instr),
    .stat       (stat),
    .rsa        (rsa),
    .rsb        (rsb),
    .pc_in      (pc_in),
    .alu_result (alu_result),
    .stat_in    (stat_in),
    .stat_en    (stat_en),
    .br_addr    (br_addr),
    .alu_op     (alu_op),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .br_sel     (br_sel),
    .pc_sel     (pc_sel),
    .pc_write   (pc_write),
    .ir_load    (ir_load)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All strobes packed: {ir_load,pc_write,pc_sel,rf_we,stat_en,br_sel,wb_sel}
  function automatic logic [6:0] strobes();
    return {ir_load, pc_write, pc_sel, rf_we, stat_en, br_sel, wb_sel};
  endfunction

  // Entered while in FETCH; walks one ALU instruction and returns in FETCH.
  task automatic run_alu(input string tag, input logic [3:0] op, input logic [3:0] mm,
                         input logic [15:0] imm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [3:0] exp_fl,
                         input logic [1:0] exp_op);
    instr = {op, mm, 8'h00, imm};
    rsa = a;
    rsb = b;
    tick();
    check_eq({tag, "_dec_en"}, {31'd0, stat_en}, 32'd0);
    tick();
    check_eq({tag, "_res"},   alu_result, exp_res);
    check_eq({tag, "_flags"}, {28'd0, stat_in}, {28'd0, exp_fl});
    check_eq({tag, "_ex_en"}, {30'd0, alu_op, stat_en}, {29'd0, exp_op, 1'b1});
    tick();
    check_eq({tag, "_mem"}, {25'd0, strobes()}, 32'd0);
    check_eq({tag, "_pass"}, alu_result, b);
    tick();
    check_eq({tag, "_wb"}, {30'd0, rf_we, wb_sel}, 32'd2);
    tick();
    check_eq({tag, "_fetch"}, {30'd0, ir_load, pc_write}, 32'd3);
  endtask

  task automatic run_br(input string tag, input logic [31:0] ins, input logic [3:0] st,
                        input logic [15:0] pc, input logic taken, input logic exp_bs,
                        input logic [15:0] exp_addr);
    instr = ins;
    stat  = st;
    pc_in = pc;
    tick();
    check_eq({tag, "_dec"}, {29'd0, pc_write, pc_sel, br_sel}, {29'd0, taken, taken, exp_bs});
    if (taken) check_eq({tag, "_addr"}, {16'd0, br_addr}, {16'd0, exp_addr});
    tick();
    check_eq({tag, "_ex"}, {25'd0, strobes()}, 32'd0);
    tick();
    tick();
    check_eq({tag, "_wb"}, {31'd0, rf_we}, 32'd0);
    tick();
    check_eq({tag, "_fetch"}, {31'd0, ir_load}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_f = 1'b0;
    instr = 32'h0;
    stat  = 4'h0;
    rsa   = 32'h0;
    rsb   = 32'h0;
    pc_in = 16'h0;
    #12;
    check_eq("rst_strobes", {25'd0, strobes()}, 32'd0);
    check_eq("rst_aluop", {30'd0, alu_op}, 32'd2);
    @(negedge clk);
    rst_f = 1'b1;
    tick();
    check_eq("start1", {25'd0, strobes()}, 32'd0);
    tick();
    check_eq("fetch0", {30'd0, ir_load, pc_write}, 32'd3);
    check_eq("fetch0_pcsel", {31'd0, pc_sel}, 32'd0);

    // ALU vectors: ADD overflow, SUB zero, SUB borrow, shifts, logic, NOT, undefined func, ADDI
    run_alu("add_ovf", 4'h1, 4'h1, 16'h0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0110, 2'b00);
    run_alu("sub_zero", 4'h1, 4'h2, 16'h0, 32'h5, 32'h5, 32'h0, 4'b1001, 2'b00);
    run_alu("sub_brw", 4'h1, 4'h2, 16'h0, 32'h3, 32'h5, 32'hFFFF_FFFE, 4'b0010, 2'b00);
    run_alu("and_z", 4'h1, 4'h3, 16'h0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 4'b0001, 2'b00);
    run_alu("xor", 4'h1, 4'h5, 16'h0, 32'h0000_F0F0, 32'h0000_FFFF, 32'h0000_0F0F, 4'b0000, 2'b00);
    run_alu("not", 4'h1, 4'h6, 16'h0, 32'h0, 32'h1234, 32'hFFFF_FFFF, 4'b0010, 2'b00);
    run_alu("shl", 4'h1, 4'h7, 16'h0, 32'h1, 32'h0000_003F, 32'h8000_0000, 4'b0010, 2'b00);
    run_alu("shr", 4'h1, 4'h8, 16'h0, 32'h8000_0000, 32'h4, 32'h0800_0000, 4'b0000, 2'b00);
    run_alu("fn9", 4'h1, 4'h9, 16'h0, 32'h55, 32'h66, 32'h0, 4'b0001, 2'b00);
    run_alu("addi", 4'h8, 4'h0, 16'hFFFF, 32'h10, 32'h77, 32'h0000_000F, 4'b1000, 2'b01);

    // Branches
    run_br("bra_t", 32'h2100_0040, 4'b0001, 16'h0100, 1'b1, 1'b1, 16'h0040);
    run_br("brr_t", 32'h3100_FFFE, 4'b0001, 16'h0005, 1'b1, 1'b0, 16'h0003);
    run_br("brr_wrap", 32'h3100_0010, 4'b0001, 16'hFFF8, 1'b1, 1'b0, 16'h0008);
    run_br("bnr_nt", 32'h5100_0004, 4'b0001, 16'h0005, 1'b0, 1'b0, 16'h0000);
    run_br("bne_t", 32'h4200_0123, 4'b0001, 16'h0005, 1'b1, 1'b1, 16'h0123);
    run_br("bra_mm0", 32'h2000_0040, 4'b1111, 16'h0005, 1'b0, 1'b1, 16'h0000);

    // Unknown opcode behaves as NOP
    instr = 32'h7100_0000;
    tick();
    check_eq("nop_dec", {25'd0, strobes()}, 32'd0);
    tick();
    check_eq("nop_ex", {25'd0, strobes()}, 32'd0);
    tick();
    tick();
    check_eq("nop_wb", {25'd0, strobes()}, 32'd0);
    tick();

    // Reset asserted mid-EXECUTE
    instr = 32'h1100_0000;
    rsa = 32'h1;
    rsb = 32'h1;
    tick();
    tick();
    check_eq("pre_rst_en", {31'd0, stat_en}, 32'd1);
    rst_f = 1'b0;
    #1;
    check_eq("mid_rst", {25'd0, strobes()}, 32'd0);
    check_eq("mid_rst_op", {30'd0, alu_op}, 32'd2);
    tick();
    check_eq("rst_hold", {25'd0, strobes()}, 32'd0);
    @(negedge clk);
    rst_f = 1'b1;
    tick();
    check_eq("rel_start1", {25'd0, strobes()}, 32'd0);
    tick();
    check_eq("rel_fetch", {31'd0, ir_load}, 32'd1);

    // HALT is absorbing
    instr = 32'hF000_0000;
    tick();
    check_eq("halt_dec", {25'd0, strobes()}, 32'd0);
    instr = 32'h1100_0000;
    repeat (10) tick();
    check_eq("halted", {29'd0, ir_load, pc_write, rf_we}, 32'd0);
    check_eq("halted_en", {31'd0, stat_en}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sisc_ctrl_exec
`default_nettype wire
